// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: streams a host program into the instruction memory,
// then releases the core and gates its fetch path while it is not running.
module imem_boot_loader #(
   parameter int ADDR_W          = 10,
   parameter int DATA_W          = 32,
   parameter bit RUN_AFTER_RESET = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [31:0]       cpu_pc,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic              cpu_run,
   output logic              fetch_misalign,
   output logic              fetch_oob,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              err_overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_RUN
   } state_t;

   localparam state_t            RST_STATE = RUN_AFTER_RESET ? S_RUN : S_IDLE;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic              err_overflow_q, err_overflow_d;
   logic              handshake;

   assign ld_ready  = (state_q == S_LOAD);
   assign handshake = ld_valid & ld_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RST_STATE;
         wr_ptr_q       <= '0;
         word_count_q   <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         word_count_q   <= word_count_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      word_count_d   = word_count_q;
      err_overflow_d = err_overflow_q;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (load_start) begin
               state_d        = S_LOAD;
               wr_ptr_d       = '0;
               word_count_d   = '0;
               err_overflow_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (handshake) begin
               word_count_d = word_count_q + CNT_ONE;
               // The pointer parks on the top word so a runaway stream can never wrap onto word 0.
               if (wr_ptr_q == LAST_ADDR) begin
                  state_d        = S_FLUSH;
                  err_overflow_d = ~ld_last;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
               end
               if (ld_last) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_we       = handshake;
   assign mem_waddr    = wr_ptr_q;
   assign mem_wdata    = ld_data;
   assign cpu_run      = (state_q == S_RUN);
   assign load_done    = (state_q == S_FLUSH);
   assign word_count   = word_count_q;
   assign err_overflow = err_overflow_q;

   // Misaligned fetches still read the enclosing word; the core decides whether to trap.
   assign mem_raddr      = cpu_pc[ADDR_W+1:2];
   assign fetch_misalign = cpu_run & (|cpu_pc[1:0]);
   assign fetch_oob      = cpu_run & (|cpu_pc[31:ADDR_W+2]);
   assign instr          = (cpu_run & ~fetch_oob) ? mem_rdata : '0;

endmodule
